zb_demux_router: RTL and testbench
==================================

# zb_demux_router

Parametrised, registered 1-to-N_CH demultiplexer for the Zigbee baseband datapath. It generalises the earlier 1-bit, 4-way MUX1 in three ways: a configurable data width and channel count, valid/ready backpressure per channel, and frame-granular routing, where the select is latched on the first beat and held until the last. Frames addressed to a non-existent channel are dropped and counted.

## Interface
- DATA_W, 8: data word width (≥1)
- N_CH, 4: number of output channels (2..16)
- SEL_W, 2: select width, ≥ clog2(N_CH); select values ≥ N_CH are legal and mean drop
- CNT_W, 8: drop-counter width
- HOLD_DATA, 1: 1 = idle channel outData holds last word; 0 = zeroed when not valid

Ports:
- inClock  in  1  system clock, rising edge
- inReset  in  1  asynchronous, active-low reset
- inData  in  DATA_W  input word
- inValid  in  1  input word valid
- inLast  in  1  marks final word of frame
- inSel  in  SEL_W  destination channel, sampled on first beat only
- inReady  out  1  input accepted this cycle when inValid&inReady
- outData  out  N_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
- outValid  out  N_CH  per-channel valid
- outLast  out  N_CH  per-channel last flag
- outReady  in  N_CH  per-channel downstream ready
- outDropCnt  out  CNT_W  saturating count of dropped frames
- outBusy  out  1  high while mid-frame (state ≠ IDLE)

## Operation
- FSM states: IDLE, ROUTE, DROP.
- Target channel tgt:
  - in IDLE, tgt = inSel (combinational);
  - in ROUTE, tgt = latched selReg.
- IDLE, first beat accepted (inValid&inReady):
  - inSel < N_CH: selReg←inSel; go to ROUTE unless inLast.
  - inSel ≥ N_CH: treat as drop beat; go to DROP unless inLast.
- ROUTE: each accepted beat goes to channel selReg. The accepted beat with inLast returns to IDLE.
- DROP: inReady=1 unconditionally, beats discarded. The accepted beat with inLast returns to IDLE.
- Drop counter: increments by 1 once per dropped frame, on the frame's last beat (a single-beat drop frame counts immediately). It saturates at 2^CNT_W−1.
- Per-channel output register (one entry):
  - load when a beat is routed to c;
  - clear valid when outValid[c]&outReady[c] and no new load;
  - a simultaneous load and drain loads the new word.
- inReady:
  - IDLE with inSel ≥ N_CH, or DROP: 1;
  - otherwise: !outValid[tgt] || outReady[tgt].
- Channels other than tgt are unaffected, so draining continues independently.
- inSel changes after the first beat are ignored until IDLE.

## Timing
- Latency: one cycle. A word accepted at edge k appears on outData/outValid/outLast of its channel after edge k.
- Throughput: 1 word/cycle per frame when outReady[tgt] is held high.
- Reset (inReset=0, async), all of the following are 0 and the FSM is in IDLE:
  - outValid, outLast, outData, outDropCnt, selReg, outBusy.
- A reset asserted mid-frame discards the frame and any registered words; it does not count a drop.
- inValid=0: no state change; inReady is still driven per the rules above.
- HOLD_DATA=0: a channel's outData reads 0 whenever outValid[c]=0.
- outBusy is registered and equals (state≠IDLE).

## Structure
- Shared package zb_demux_pkg:
  - state enum (IDLE=2'd0, ROUTE=2'd1, DROP=2'd2);
  - default parameter constants;
  - function for channel slice index.
- Sub-module zb_chan_reg: the one-entry valid/data/last output register per channel, instantiated N_CH times via generate. It takes the load, word and last inputs and the outReady drain input.

## Test plan
- Reset: hold inReset=0 for 5 cycles with random inputs, then check every output is 0, inReady matches the rule, and outBusy=0.
- Frame routing (DATA_W=8, N_CH=4, all outReady=1):
  - stimulus: inSel=2 latched; words 0x11,0x22,0x33 with last on 0x33; inSel toggled mid-frame;
  - response: only channel 2 valid, one cycle later each, outLast with 0x33; FSM back to IDLE.
- Backpressure: outReady[1]=0 with a 2-word frame to channel 1.
  - First word registered, inReady drops to 0, and the second word is held.
  - Raising outReady[1] drains 0xA0, then 0xA1 follows the next cycle.
  - Channel 0 drains concurrently and unaffected.
- Drop (N_CH=3, SEL_W=2): inSel=3, 4-beat frame.
  - Response: inReady=1 throughout, no outValid, outDropCnt 0→1 on the last beat.
  - Next, a single-beat drop frame gives outDropCnt=2.
  - With CNT_W=2, repeat until saturated at 3.
- Reset mid-frame: assert inReset after 2 of 5 beats to channel 0.
  - Outputs clear at once.
  - After release, a new frame to channel 3 routes correctly and outDropCnt is unchanged.
- HOLD_DATA: a frame to channel 1 ending in 0x5A, then drain.
  - HOLD_DATA=1: outData slice stays 0x5A.
  - HOLD_DATA=0: slice reads 0x00 once outValid[1]=0.

Source files
------------

// File: rtl/zb_demux_router_pkg.sv
// zb_demux_pkg: shared state encoding, default parameters and slice helper for the demux router.
package zb_demux_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ROUTE = 2'd1, DROP = 2'd2} state_e;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_N_CH   = 4;
    localparam int DEF_SEL_W  = 2;
    localparam int DEF_CNT_W  = 8;
    function automatic int slice_lo(input int c, input int w);
        return c * w;
    endfunction
endpackage

// File: rtl/zb_demux_router_if.sv
// zb_demux_router_if: input stream, per-channel output streams and status of the demux router.
interface zb_demux_router_if #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
);
    logic [DATA_W-1:0]      inData;
    logic                   inValid;
    logic                   inLast;
    logic [SEL_W-1:0]       inSel;
    logic                   inReady;
    logic [N_CH*DATA_W-1:0] outData;
    logic [N_CH-1:0]        outValid;
    logic [N_CH-1:0]        outLast;
    logic [N_CH-1:0]        outReady;
    logic [CNT_W-1:0]       outDropCnt;
    logic                   outBusy;
    modport slave (
        input  inData, inValid, inLast, inSel, outReady,
        output inReady, outData, outValid, outLast, outDropCnt, outBusy
    );
    modport master (
        output inData, inValid, inLast, inSel, outReady,
        input  inReady, outData, outValid, outLast, outDropCnt, outBusy
    );
endinterface

// File: rtl/zb_demux_router_chan_reg.sv
// zb_chan_reg: one-entry valid/data/last output register for a single demux channel.
module zb_chan_reg #(
    parameter int DATA_W    = 8,
    parameter bit HOLD_DATA = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o
);
    logic              valid_q, last_q;
    logic [DATA_W-1:0] data_q;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= load_i ? 1'b1 : (valid_q && ready_i) ? 1'b0 : valid_q;
            last_q  <= load_i ? last_i : last_q;
            data_q  <= load_i ? data_i : data_q;
        end
    assign valid_o = valid_q;
    assign last_o  = valid_q && last_q;
    assign data_o  = (HOLD_DATA || valid_q) ? data_q : '0;
endmodule

// File: rtl/zb_demux_router.sv
// zb_demux_router: frame-granular 1-to-N_CH registered demux with per-channel backpressure
// and a saturating counter of frames dropped for an out-of-range select.
module zb_demux_router
    import zb_demux_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int N_CH      = DEF_N_CH,
    parameter int SEL_W     = DEF_SEL_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter bit HOLD_DATA = 1'b1
) (
    input logic               inClock,
    input logic               inReset,
    zb_demux_router_if.slave  bus
);
    localparam logic [SEL_W:0] NCH = (SEL_W + 1)'(N_CH);
    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d, tgt;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, bad_sel, drop, rdy, acc, cnt_inc;
    logic [N_CH-1:0]  load;
    always_ff @(posedge inClock or negedge inReset)
        if (!inReset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_q + CNT_W'(cnt_inc);
            busy_q  <= state_d != IDLE;
        end
    // Select is only live on the first beat; afterwards the latched channel steers the frame.
    always_comb begin
        tgt     = (state_q == IDLE) ? bus.inSel : sel_q;
        bad_sel = (state_q == IDLE) && ({1'b0, bus.inSel} >= NCH);
        drop    = bad_sel || (state_q == DROP);
        rdy     = drop || !bus.outValid[tgt] || bus.outReady[tgt];
        acc     = bus.inValid && rdy;
        state_d = !acc ? state_q :
                  bus.inLast ? IDLE :
                  (state_q == IDLE) ? (bad_sel ? DROP : ROUTE) : state_q;
        sel_d   = (acc && state_q == IDLE && !bad_sel) ? bus.inSel : sel_q;
    end
    always_comb begin
        bus.inReady    = rdy;
        bus.outBusy    = busy_q;
        bus.outDropCnt = cnt_q;
        cnt_inc        = acc && drop && bus.inLast && (cnt_q != '1);
        for (int c = 0; c < N_CH; c++)
            load[c] = acc && !drop && (tgt == SEL_W'(c));
    end
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        zb_chan_reg #(.DATA_W(DATA_W), .HOLD_DATA(HOLD_DATA)) u_ch (
            .clk_i  (inClock),
            .rst_ni (inReset),
            .load_i (load[g]),
            .data_i (bus.inData),
            .last_i (bus.inLast),
            .ready_i(bus.outReady[g]),
            .valid_o(bus.outValid[g]),
            .data_o (bus.outData[slice_lo(g, DATA_W) +: DATA_W]),
            .last_o (bus.outLast[g])
        );
    end
endmodule

// File: tb/tb_zb_demux_router.sv
// tb_zb_demux_router: directed checks of routing, backpressure, drop counting, reset and hold behaviour.
module tb_zb_demux_router;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    always #5 clk = ~clk;

    zb_demux_router_if #(.DATA_W(8), .N_CH(4), .SEL_W(2), .CNT_W(8)) ia ();
    zb_demux_router_if #(.DATA_W(8), .N_CH(3), .SEL_W(2), .CNT_W(2)) ib ();

    zb_demux_router #(.DATA_W(8), .N_CH(4), .SEL_W(2), .CNT_W(8), .HOLD_DATA(1'b1)) dut_a (
        .inClock(clk), .inReset(rst_n), .bus(ia.slave));
    zb_demux_router #(.DATA_W(8), .N_CH(3), .SEL_W(2), .CNT_W(2), .HOLD_DATA(1'b0)) dut_b (
        .inClock(clk), .inReset(rst_n), .bus(ib.slave));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ia.inValid = 1'b0; ia.inLast = 1'b0; ia.inData = 8'h00; ia.inSel = 2'd0; ia.outReady = 4'hF;
        ib.inValid = 1'b0; ib.inLast = 1'b0; ib.inData = 8'h00; ib.inSel = 2'd0; ib.outReady = 3'h7;
    endtask

    task automatic drive_a(input logic [1:0] sel, input logic [7:0] d, input logic last);
        ia.inValid = 1'b1; ia.inSel = sel; ia.inData = d; ia.inLast = last;
    endtask

    task automatic drive_b(input logic [1:0] sel, input logic [7:0] d, input logic last);
        ib.inValid = 1'b1; ib.inSel = sel; ib.inData = d; ib.inLast = last;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ia.inValid = 1'($urandom); ia.inLast = 1'($urandom); ia.inData = 8'($urandom);
            ia.inSel = 2'($urandom); ia.outReady = 4'($urandom);
            ib.inValid = 1'($urandom); ib.inLast = 1'($urandom); ib.inData = 8'($urandom);
            ib.inSel = 2'($urandom); ib.outReady = 3'($urandom);
            tick();
        end
        tests++; if (ia.outValid !== 4'h0) begin fails++; $display("FAIL reset_a_valid got %h exp 0", ia.outValid); end
        tests++; if (ia.outLast !== 4'h0) begin fails++; $display("FAIL reset_a_last got %h exp 0", ia.outLast); end
        tests++; if (ia.outData !== 32'h0) begin fails++; $display("FAIL reset_a_data got %h exp 0", ia.outData); end
        tests++; if (ia.outDropCnt !== 8'h0) begin fails++; $display("FAIL reset_a_cnt got %h exp 0", ia.outDropCnt); end
        tests++; if (ia.outBusy !== 1'b0) begin fails++; $display("FAIL reset_a_busy got %b exp 0", ia.outBusy); end
        tests++; if (ia.inReady !== 1'b1) begin fails++; $display("FAIL reset_a_ready got %b exp 1", ia.inReady); end
        tests++; if (ib.outValid !== 3'h0 || ib.outData !== 24'h0 || ib.outDropCnt !== 2'h0 || ib.outBusy !== 1'b0)
            begin fails++; $display("FAIL reset_b_outs got v=%h d=%h c=%h b=%b exp all 0", ib.outValid, ib.outData, ib.outDropCnt, ib.outBusy); end
        tests++; if (ib.inReady !== 1'b1) begin fails++; $display("FAIL reset_b_ready got %b exp 1", ib.inReady); end
        idle_inputs();
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_route;
        drive_a(2'd2, 8'h11, 1'b0);
        #1;
        tests++; if (ia.inReady !== 1'b1) begin fails++; $display("FAIL route_ready got %b exp 1", ia.inReady); end
        tick();
        tests++; if (ia.outValid !== 4'b0100 || ia.outData[23:16] !== 8'h11 || ia.outLast !== 4'h0)
            begin fails++; $display("FAIL route_w0 got v=%b d=%h l=%b exp v=0100 d=11 l=0000", ia.outValid, ia.outData[23:16], ia.outLast); end
        tests++; if (ia.outBusy !== 1'b1) begin fails++; $display("FAIL route_busy got %b exp 1", ia.outBusy); end
        drive_a(2'd1, 8'h22, 1'b0);
        tick();
        tests++; if (ia.outValid !== 4'b0100 || ia.outData[23:16] !== 8'h22)
            begin fails++; $display("FAIL route_w1 got v=%b d=%h exp v=0100 d=22", ia.outValid, ia.outData[23:16]); end
        drive_a(2'd3, 8'h33, 1'b1);
        tick();
        tests++; if (ia.outValid !== 4'b0100 || ia.outData[23:16] !== 8'h33 || ia.outLast !== 4'b0100)
            begin fails++; $display("FAIL route_w2 got v=%b d=%h l=%b exp v=0100 d=33 l=0100", ia.outValid, ia.outData[23:16], ia.outLast); end
        tests++; if (ia.outBusy !== 1'b0) begin fails++; $display("FAIL route_idle got busy=%b exp 0", ia.outBusy); end
        idle_inputs();
        tick();
        tests++; if (ia.outValid !== 4'h0) begin fails++; $display("FAIL route_drain got %b exp 0000", ia.outValid); end
    endtask

    task automatic test_backpressure;
        ia.outReady = 4'h0;
        drive_a(2'd0, 8'hC0, 1'b1);
        tick();
        drive_a(2'd1, 8'hA0, 1'b0);
        #1;
        tests++; if (ia.inReady !== 1'b1) begin fails++; $display("FAIL bp_ready0 got %b exp 1", ia.inReady); end
        tick();
        tests++; if (ia.outValid !== 4'b0011 || ia.outData[15:8] !== 8'hA0)
            begin fails++; $display("FAIL bp_w0 got v=%b d=%h exp v=0011 d=a0", ia.outValid, ia.outData[15:8]); end
        drive_a(2'd1, 8'hA1, 1'b1);
        #1;
        tests++; if (ia.inReady !== 1'b0) begin fails++; $display("FAIL bp_stall got %b exp 0", ia.inReady); end
        tick();
        tests++; if (ia.outValid !== 4'b0011 || ia.outData[15:8] !== 8'hA0 || ia.outBusy !== 1'b1)
            begin fails++; $display("FAIL bp_hold got v=%b d=%h b=%b exp v=0011 d=a0 b=1", ia.outValid, ia.outData[15:8], ia.outBusy); end
        ia.outReady = 4'b0011;
        #1;
        tests++; if (ia.inReady !== 1'b1) begin fails++; $display("FAIL bp_release got %b exp 1", ia.inReady); end
        tick();
        tests++; if (ia.outValid !== 4'b0010 || ia.outData[15:8] !== 8'hA1 || ia.outLast !== 4'b0010)
            begin fails++; $display("FAIL bp_w1 got v=%b d=%h l=%b exp v=0010 d=a1 l=0010", ia.outValid, ia.outData[15:8], ia.outLast); end
        idle_inputs();
        tick();
        tests++; if (ia.outValid !== 4'h0 || ia.outBusy !== 1'b0)
            begin fails++; $display("FAIL bp_end got v=%b b=%b exp v=0000 b=0", ia.outValid, ia.outBusy); end
    endtask

    task automatic test_drop;
        logic [1:0] exp_cnt;
        ib.outReady = 3'h0;
        for (int i = 0; i < 4; i++) begin
            drive_b(i == 1 ? 2'd0 : 2'd3, 8'(8'h40 + i), i == 3);
            #1;
            tests++; if (ib.inReady !== 1'b1) begin fails++; $display("FAIL drop_ready%0d got %b exp 1", i, ib.inReady); end
            tick();
            exp_cnt = (i == 3) ? 2'd1 : 2'd0;
            tests++; if (ib.outValid !== 3'h0 || ib.outDropCnt !== exp_cnt)
                begin fails++; $display("FAIL drop_beat%0d got v=%b c=%0d exp v=000 c=%0d", i, ib.outValid, ib.outDropCnt, exp_cnt); end
        end
        tests++; if (ib.outBusy !== 1'b0) begin fails++; $display("FAIL drop_idle got busy=%b exp 0", ib.outBusy); end
        for (int i = 0; i < 3; i++) begin
            drive_b(2'd3, 8'h99, 1'b1);
            tick();
            exp_cnt = (i == 0) ? 2'd2 : 2'd3;
            tests++; if (ib.outDropCnt !== exp_cnt || ib.outValid !== 3'h0)
                begin fails++; $display("FAIL drop_single%0d got c=%0d v=%b exp c=%0d v=000", i, ib.outDropCnt, ib.outValid, exp_cnt); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid;
        drive_a(2'd0, 8'h01, 1'b0);
        tick();
        drive_a(2'd0, 8'h02, 1'b0);
        tick();
        tests++; if (ia.outValid !== 4'b0001 || ia.outBusy !== 1'b1)
            begin fails++; $display("FAIL rmid_pre got v=%b b=%b exp v=0001 b=1", ia.outValid, ia.outBusy); end
        idle_inputs();
        rst_n = 1'b0;
        #1;
        tests++; if (ia.outValid !== 4'h0 || ia.outData !== 32'h0 || ia.outBusy !== 1'b0)
            begin fails++; $display("FAIL rmid_clear got v=%b d=%h b=%b exp all 0", ia.outValid, ia.outData, ia.outBusy); end
        tick();
        rst_n = 1'b1;
        tick();
        drive_a(2'd3, 8'h77, 1'b1);
        tick();
        tests++; if (ia.outValid !== 4'b1000 || ia.outData[31:24] !== 8'h77 || ia.outLast !== 4'b1000)
            begin fails++; $display("FAIL rmid_route got v=%b d=%h l=%b exp v=1000 d=77 l=1000", ia.outValid, ia.outData[31:24], ia.outLast); end
        tests++; if (ia.outDropCnt !== 8'h0) begin fails++; $display("FAIL rmid_cnt got %0d exp 0", ia.outDropCnt); end
        idle_inputs();
        tick();
    endtask

    task automatic test_hold;
        drive_a(2'd1, 8'h5A, 1'b1);
        drive_b(2'd1, 8'h5A, 1'b1);
        tick();
        tests++; if (ia.outValid !== 4'b0010 || ia.outData[15:8] !== 8'h5A)
            begin fails++; $display("FAIL hold_a_load got v=%b d=%h exp v=0010 d=5a", ia.outValid, ia.outData[15:8]); end
        tests++; if (ib.outValid !== 3'b010 || ib.outData[15:8] !== 8'h5A)
            begin fails++; $display("FAIL hold_b_load got v=%b d=%h exp v=010 d=5a", ib.outValid, ib.outData[15:8]); end
        idle_inputs();
        tick();
        tests++; if (ia.outValid !== 4'h0 || ia.outData[15:8] !== 8'h5A)
            begin fails++; $display("FAIL hold_a_keep got v=%b d=%h exp v=0000 d=5a", ia.outValid, ia.outData[15:8]); end
        tests++; if (ib.outValid !== 3'h0 || ib.outData[15:8] !== 8'h00)
            begin fails++; $display("FAIL hold_b_zero got v=%b d=%h exp v=000 d=00", ib.outValid, ib.outData[15:8]); end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_route();
        test_backpressure();
        test_drop();
        test_reset_mid();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
